axil_memtest_sequencer: RTL and testbench

Hardware AXI4-Lite master that runs the memtest register write/read-back sequence without a BFM. On `start` it walks `NUM_WORDS` consecutive 32-bit words from `BASE_ADDR`. For each word it writes a seed-derived pattern, reads the word back, checks both responses and the data, and records a pass/fail summary. It sits between control logic (or a PS-side GPIO) and the memtest S00_AXI slave port, and is the only master on that port.

---
 rtl/axil_memtest_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_axil_memtest_sequencer.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_memtest_sequencer.sv
// AXI4-Lite master that writes seed+i to NUM_WORDS consecutive words, reads each back,
// and reports how many words failed and the address of the first failure.
module axil_memtest_sequencer #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned NUM_WORDS = 4
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic        start,
  input  logic [31:0] seed,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [7:0]  err_count,
  output logic [31:0] first_err_addr,
  output logic [31:0] m_axi_awaddr,
  output logic [2:0]  m_axi_awprot,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  output logic [31:0] m_axi_araddr,
  output logic [2:0]  m_axi_arprot,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready
);

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StWresp,
    StRead,
    StRdata,
    StCheck,
    StFin
  } state_e;

  localparam logic [8:0] LastIdx = 9'(NUM_WORDS - 1);

  function automatic logic [31:0] word_addr(input logic [8:0] idx);
    return BASE_ADDR + {21'd0, idx, 2'b00};
  endfunction

  state_e      state_q, state_d;
  logic [8:0]  idx_q, idx_d;
  logic [31:0] seed_q, seed_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        berr_q, berr_d;
  logic        rerr_q, rerr_d;
  logic [31:0] rdata_q, rdata_d;
  logic [7:0]  err_count_q, err_count_d;
  logic [31:0] first_err_q, first_err_d;
  logic        pass_q, pass_d;
  logic        word_fail;
  logic [8:0]  idx_inc;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    seed_d      = seed_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    berr_d      = berr_q;
    rerr_d      = rerr_q;
    rdata_d     = rdata_q;
    err_count_d = err_count_q;
    first_err_d = first_err_q;
    pass_d      = pass_q;
    word_fail   = berr_q || rerr_q || (rdata_q != wdata_q);
    idx_inc     = idx_q + 9'd1;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          seed_d      = seed;
          idx_d       = 9'd0;
          err_count_d = 8'd0;
          first_err_d = 32'd0;
          pass_d      = 1'b0;
          addr_d      = word_addr(9'd0);
          wdata_d     = seed;
          awvalid_d   = 1'b1;
          wvalid_d    = 1'b1;
          state_d     = StWrite;
        end
      end
      StWrite: begin
        // Each channel drops its valid after its own handshake; leave once both are done.
        if (m_axi_awready) awvalid_d = 1'b0;
        if (m_axi_wready)  wvalid_d  = 1'b0;
        if ((!awvalid_q || m_axi_awready) && (!wvalid_q || m_axi_wready)) begin
          awvalid_d = 1'b0;
          wvalid_d  = 1'b0;
          state_d   = StWresp;
        end
      end
      StWresp: begin
        if (m_axi_bvalid) begin
          berr_d  = (m_axi_bresp != 2'b00);
          state_d = StRead;
        end
      end
      StRead: begin
        if (m_axi_arready) state_d = StRdata;
      end
      StRdata: begin
        if (m_axi_rvalid) begin
          rdata_d = m_axi_rdata;
          rerr_d  = (m_axi_rresp != 2'b00);
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (word_fail) begin
          if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
          if (err_count_q == 8'd0)  first_err_d = addr_q;
        end
        if (idx_q == LastIdx) begin
          // Resolve pass on the way into FIN so it is already valid alongside done.
          pass_d  = (err_count_d == 8'd0);
          state_d = StFin;
        end else begin
          idx_d     = idx_inc;
          addr_d    = word_addr(idx_inc);
          wdata_d   = seed_q + 32'(idx_inc);
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          state_d   = StWrite;
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q     <= StIdle;
      idx_q       <= 9'd0;
      seed_q      <= 32'd0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      berr_q      <= 1'b0;
      rerr_q      <= 1'b0;
      rdata_q     <= 32'd0;
      err_count_q <= 8'd0;
      first_err_q <= 32'd0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      seed_q      <= seed_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      berr_q      <= berr_d;
      rerr_q      <= rerr_d;
      rdata_q     <= rdata_d;
      err_count_q <= err_count_d;
      first_err_q <= first_err_d;
      pass_q      <= pass_d;
    end
  end

  assign busy           = (state_q != StIdle);
  assign done           = (state_q == StFin);
  assign pass           = pass_q;
  assign err_count      = err_count_q;
  assign first_err_addr = first_err_q;

  assign m_axi_awaddr  = addr_q;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = 4'hF;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = (state_q == StWresp);
  assign m_axi_araddr  = addr_q;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = (state_q == StRead);
  assign m_axi_rready  = (state_q == StRdata);

endmodule

// File: tb/tb_axil_memtest_sequencer.sv
// Scoreboard bench: two sequencers (4 words and 256 words), each against its own slave model.
module tb_axil_memtest_sequencer;

  logic tb_ACLK = 1'b0;
  logic tb_ARESET;
  always #5 tb_ACLK = ~tb_ACLK;

  // dut0: NUM_WORDS=4 against a configurable memory slave
  logic        start, busy, done, pass;
  logic [31:0] seed, first_err_addr;
  logic [7:0]  err_count;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  // dut1: NUM_WORDS=256 against a slave that always reads 0
  logic        start_1, busy_1, done_1, pass_1;
  logic [31:0] seed_1, first_err_addr_1;
  logic [7:0]  err_count_1;
  logic [31:0] awaddr_1, wdata_1, araddr_1;
  logic [2:0]  awprot_1, arprot_1;
  logic [3:0]  wstrb_1;
  logic        awvalid_1, wvalid_1, bvalid_1, bready_1, arvalid_1, rvalid_1, rready_1;

  axil_memtest_sequencer #(.BASE_ADDR(32'h0), .NUM_WORDS(4)) u_dut0 (
    .ACLK(tb_ACLK), .ARESET(tb_ARESET), .start(start), .seed(seed), .busy(busy),
    .done(done), .pass(pass), .err_count(err_count), .first_err_addr(first_err_addr),
    .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid),
    .m_axi_awready(awready), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_bresp(bresp),
    .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_araddr(araddr),
    .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  axil_memtest_sequencer #(.BASE_ADDR(32'h0), .NUM_WORDS(256)) u_dut1 (
    .ACLK(tb_ACLK), .ARESET(tb_ARESET), .start(start_1), .seed(seed_1), .busy(busy_1),
    .done(done_1), .pass(pass_1), .err_count(err_count_1),
    .first_err_addr(first_err_addr_1), .m_axi_awaddr(awaddr_1), .m_axi_awprot(awprot_1),
    .m_axi_awvalid(awvalid_1), .m_axi_awready(1'b1), .m_axi_wdata(wdata_1),
    .m_axi_wstrb(wstrb_1), .m_axi_wvalid(wvalid_1), .m_axi_wready(1'b1),
    .m_axi_bresp(2'b00), .m_axi_bvalid(bvalid_1), .m_axi_bready(bready_1),
    .m_axi_araddr(araddr_1), .m_axi_arprot(arprot_1), .m_axi_arvalid(arvalid_1),
    .m_axi_arready(1'b1), .m_axi_rdata(32'h0), .m_axi_rresp(2'b00),
    .m_axi_rvalid(rvalid_1), .m_axi_rready(rready_1)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int t0    = 0;
  int stab_err = 0;
  always @(posedge tb_ACLK) cyc <= cyc + 1;

  typedef struct {
    bit          pass;
    logic [7:0]  err;
    logic [31:0] first;
    int          lat;
  } res_t;

  res_t        res_q[$];
  res_t        res1_q[$];
  logic [63:0] wexp_q[$];
  logic [31:0] rexp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- slave model for dut0 ----------------
  int          aw_stall = 0, w_stall = 0, aw_cnt = 0, w_cnt = 0;
  logic [31:0] corrupt_addr = '1, bresp_err_addr = '1, rresp_err_addr = '1;
  logic        got_aw, got_w, b_gap;
  logic [31:0] sa_addr, sa_data, s_wa, s_wd;
  logic [31:0] mem [0:63];
  logic        fire_aw, fire_w;

  assign awready = (aw_cnt >= aw_stall);
  assign wready  = (w_cnt >= w_stall);
  assign arready = 1'b1;
  assign fire_aw = awvalid && awready;
  assign fire_w  = wvalid && wready;
  assign s_wa    = got_aw ? sa_addr : awaddr;
  assign s_wd    = got_w ? sa_data : wdata;

  always @(posedge tb_ACLK) begin
    if (tb_ARESET) begin
      aw_cnt <= 0; w_cnt <= 0; got_aw <= 1'b0; got_w <= 1'b0; b_gap <= 1'b0;
      bvalid <= 1'b0; rvalid <= 1'b0; bresp <= 2'b00; rresp <= 2'b00; rdata <= 32'h0;
      sa_addr <= 32'h0; sa_data <= 32'h0;
    end else begin
      if (awvalid && !awready) aw_cnt <= aw_cnt + 1;
      else if (fire_aw) aw_cnt <= 0;
      if (wvalid && !wready) w_cnt <= w_cnt + 1;
      else if (fire_w) w_cnt <= 0;
      if (fire_aw) begin got_aw <= 1'b1; sa_addr <= awaddr; end
      if (fire_w) begin got_w <= 1'b1; sa_data <= wdata; end
      if ((fire_aw || got_aw) && (fire_w || got_w)) begin
        mem[s_wa[7:2]] <= s_wd;
        got_aw <= 1'b0;
        got_w  <= 1'b0;
        b_gap  <= 1'b1;
        bresp  <= (s_wa == bresp_err_addr) ? 2'b10 : 2'b00;
      end
      // write response one idle cycle after the write completes
      if (b_gap) begin b_gap <= 1'b0; bvalid <= 1'b1; end
      else if (bvalid && bready) bvalid <= 1'b0;
      if (arvalid && !rvalid) begin
        rvalid <= 1'b1;
        rdata  <= (araddr == corrupt_addr) ? 32'hDEAD0011 : mem[araddr[7:2]];
        rresp  <= (araddr == rresp_err_addr) ? 2'b11 : 2'b00;
      end else if (rvalid && rready) rvalid <= 1'b0;
    end
  end

  // ---------------- slave model for dut1 ----------------
  always @(posedge tb_ACLK) begin
    if (tb_ARESET) begin
      bvalid_1 <= 1'b0; rvalid_1 <= 1'b0;
    end else begin
      if (awvalid_1 && wvalid_1) bvalid_1 <= 1'b1;
      else if (bvalid_1 && bready_1) bvalid_1 <= 1'b0;
      if (arvalid_1 && !rvalid_1) rvalid_1 <= 1'b1;
      else if (rvalid_1 && rready_1) rvalid_1 <= 1'b0;
    end
  end

  // ---------------- monitors ----------------
  initial begin : mon_write
    logic ga, gw;
    logic [31:0] a, d;
    logic [63:0] e;
    ga = 1'b0; gw = 1'b0; a = 32'h0; d = 32'h0;
    forever begin
      @(negedge tb_ACLK);
      if (tb_ARESET) begin
        ga = 1'b0; gw = 1'b0;
      end else begin
        if (fire_aw) begin ga = 1'b1; a = awaddr; end
        if (fire_w) begin gw = 1'b1; d = wdata; end
        if (ga && gw) begin
          if (wexp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_write: got %0h/%0h, expected none", a, d);
          end else begin
            e = wexp_q.pop_front();
            chk("write_addr", 64'(a), 64'(e[63:32]));
            chk("write_data", 64'(d), 64'(e[31:0]));
          end
          ga = 1'b0; gw = 1'b0;
        end
      end
    end
  end

  initial begin : mon_read
    forever begin
      @(negedge tb_ACLK);
      if (!tb_ARESET && arvalid && arready) begin
        if (rexp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_read: got %0h, expected none", araddr);
        end else chk("read_addr", 64'(araddr), 64'(rexp_q.pop_front()));
      end
    end
  end

  initial begin : mon_stable
    logic pa, pw;
    logic [31:0] la, lw;
    pa = 1'b0; pw = 1'b0; la = 32'h0; lw = 32'h0;
    forever begin
      @(negedge tb_ACLK);
      if (tb_ARESET) begin
        pa = 1'b0; pw = 1'b0;
      end else begin
        if (pa && (!awvalid || awaddr != la)) stab_err++;
        if (pw && (!wvalid || wdata != lw)) stab_err++;
        pa = awvalid && !awready; la = awaddr;
        pw = wvalid && !wready;   lw = wdata;
      end
    end
  end

  initial begin : mon_done
    res_t r;
    forever begin
      @(negedge tb_ACLK);
      if (!tb_ARESET && done) begin
        if (res_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_done: got done=1, expected 0");
        end else begin
          r = res_q.pop_front();
          chk("pass", 64'(pass), 64'(r.pass));
          chk("err_count", 64'(err_count), 64'(r.err));
          chk("first_err_addr", 64'(first_err_addr), 64'(r.first));
          if (r.lat >= 0) chk("done_latency", 64'(cyc - t0 + 1), 64'(r.lat));
        end
      end
      if (!tb_ARESET && done_1) begin
        if (res1_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_done_1: got done=1, expected 0");
        end else begin
          r = res1_q.pop_front();
          chk("pass_1", 64'(pass_1), 64'(r.pass));
          chk("err_count_1", 64'(err_count_1), 64'(r.err));
          chk("first_err_addr_1", 64'(first_err_addr_1), 64'(r.first));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic push_words(input logic [31:0] s);
    for (int i = 0; i < 4; i++) begin
      wexp_q.push_back({32'(4 * i), s + 32'(i)});
      rexp_q.push_back(32'(4 * i));
    end
  endtask

  task automatic start0(input logic [31:0] s);
    @(negedge tb_ACLK);
    seed  = s;
    start = 1'b1;
    @(posedge tb_ACLK);
    #1 t0 = cyc;
    @(negedge tb_ACLK);
    start = 1'b0;
  endtask

  task automatic run0(input logic [31:0] s, input bit p, input logic [7:0] e,
                      input logic [31:0] f, input int lat);
    res_t r;
    int k;
    r.pass = p; r.err = e; r.first = f; r.lat = lat;
    res_q.push_back(r);
    start0(s);
    k = 0;
    while (res_q.size() != 0 && k < 400) begin
      @(negedge tb_ACLK);
      k++;
    end
    if (res_q.size() != 0) begin
      tests++; fails++;
      $display("FAIL run_timeout: got no done after %0d cycles, expected done", k);
      res_q.delete(); wexp_q.delete(); rexp_q.delete();
      tb_ARESET = 1'b1;
      @(negedge tb_ACLK);
      tb_ARESET = 1'b0;
    end
    @(negedge tb_ACLK);
    chk("writes_outstanding", 64'(wexp_q.size()), 64'd0);
    chk("reads_outstanding", 64'(rexp_q.size()), 64'd0);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int k;
    res_t r;
    tb_ARESET = 1'b1;
    start = 1'b0; seed = 32'h0; start_1 = 1'b0; seed_1 = 32'h0;
    repeat (3) @(posedge tb_ACLK);
    @(negedge tb_ACLK);
    tb_ARESET = 1'b0;

    chk("rst_status", 64'({busy, done, pass, err_count}), 64'd0);
    chk("rst_first_err", 64'(first_err_addr), 64'd0);
    chk("rst_valids", 64'({awvalid, wvalid, bready, arvalid, rready}), 64'd0);
    chk("rst_addr_data", {awaddr, wdata | araddr}, 64'd0);
    chk("tied_prot_strb", 64'({awprot, wstrb, arprot}), 64'h078);

    // zero-wait: hand-computed vectors
    wexp_q.push_back({32'h0, 32'h0101FFFF});
    wexp_q.push_back({32'h4, 32'h01020000});
    wexp_q.push_back({32'h8, 32'h01020001});
    wexp_q.push_back({32'hC, 32'h01020002});
    rexp_q.push_back(32'h0); rexp_q.push_back(32'h4);
    rexp_q.push_back(32'h8); rexp_q.push_back(32'hC);
    run0(32'h0101FFFF, 1'b1, 8'd0, 32'h0, 25);

    // back-pressure on AW, then on W
    aw_stall = 3; w_stall = 0;
    push_words(32'hA5A5_0000);
    run0(32'hA5A5_0000, 1'b1, 8'd0, 32'h0, -1);
    aw_stall = 0; w_stall = 3;
    push_words(32'h5A5A_1234);
    run0(32'h5A5A_1234, 1'b1, 8'd0, 32'h0, -1);
    chk("valid_stable", 64'(stab_err), 64'd0);
    w_stall = 0;

    // corrupted read data on word 2
    corrupt_addr = 32'h8;
    push_words(32'h1000_0000);
    run0(32'h1000_0000, 1'b0, 8'd1, 32'h8, 25);
    corrupt_addr = '1;

    // SLVERR on word 1 write, DECERR on word 3 read
    bresp_err_addr = 32'h4; rresp_err_addr = 32'hC;
    push_words(32'h0000_0100);
    run0(32'h0000_0100, 1'b0, 8'd2, 32'h4, 25);
    bresp_err_addr = '1; rresp_err_addr = '1;

    // reset while in RDATA of word 0
    wexp_q.push_back({32'h0, 32'h7777_0000});
    rexp_q.push_back(32'h0);
    start0(32'h7777_0000);
    k = 0;
    while (!rready && k < 50) begin
      @(negedge tb_ACLK);
      k++;
    end
    chk("reached_rdata", 64'(rready), 64'd1);
    tb_ARESET = 1'b1;
    @(negedge tb_ACLK);
    chk("midrst_valids", 64'({awvalid, wvalid, bready, arvalid, rready}), 64'd0);
    chk("midrst_busy_done", 64'({busy, done}), 64'd0);
    tb_ARESET = 1'b0;
    chk("midrst_writes", 64'(wexp_q.size()), 64'd0);
    chk("midrst_reads", 64'(rexp_q.size()), 64'd0);

    // clean restart; pattern wraps through 2^32
    push_words(32'hFFFF_FFFE);
    run0(32'hFFFF_FFFE, 1'b1, 8'd0, 32'h0, 25);

    // 256 failing words saturate the error count
    r.pass = 1'b0; r.err = 8'd255; r.first = 32'h0; r.lat = -1;
    res1_q.push_back(r);
    @(negedge tb_ACLK);
    seed_1  = 32'h1;
    start_1 = 1'b1;
    @(negedge tb_ACLK);
    start_1 = 1'b0;
    k = 0;
    while (res1_q.size() != 0 && k < 3000) begin
      @(negedge tb_ACLK);
      k++;
    end
    chk("sat_run_finished", 64'(res1_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
